// File: rtl/seq_alu_ccstack.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_ccstack
// Purpose  : Sequenced ALU with START/BUSY/DONE handshake, bit-serial shifts,
//            shift-add multiplier, a 4-bit condition-code register and a LIFO
//            save/restore stack for those condition codes.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK        in   1      clock, rising edge
//   RESET      in   1      synchronous, active-high, highest priority
//   START      in   1      request, accepted on an edge where BUSY=0
//   OP         in   4      operation code (ADD..MOV B)
//   A, B       in   WIDTH  operands, sampled at the accepting edge
//   CCL_LD     in   1      sampled with START: update flags at DONE edge
//   CC_PUSH    in   1      push {Z,C,S,P} onto the CC stack
//   CC_POP     in   1      pop the CC stack into the flags
//   R          out  WIDTH  result register, held until next DONE
//   BUSY       out  1      multi-cycle operation in progress
//   DONE       out  1      one-cycle pulse, R valid
//   CC_ZERO/CC_CARRY/CC_SIGN/CC_PARITY  out 1  flag register
//   CC_ERR     out  1      one-cycle pulse on stack misuse
// ============================================================================
module seq_alu_ccstack #(
    parameter int WIDTH    = 16,
    parameter int CC_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [3:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CCL_LD,
    input  logic             CC_PUSH,
    input  logic             CC_POP,
    output logic [WIDTH-1:0] R,
    output logic             BUSY,
    output logic             DONE,
    output logic             CC_ZERO,
    output logic             CC_CARRY,
    output logic             CC_SIGN,
    output logic             CC_PARITY,
    output logic             CC_ERR
);

    localparam int c_SHW = $clog2(WIDTH);
    localparam int c_CW  = c_SHW + 1;
    localparam int c_SPW = $clog2(CC_DEPTH + 1);
    localparam int c_IW  = (CC_DEPTH > 1) ? $clog2(CC_DEPTH) : 1;

    localparam logic [c_CW-1:0]  c_MUL_STEPS = c_CW'(WIDTH);
    localparam logic [c_CW-1:0]  c_CNT_ONE   = c_CW'(1);
    localparam logic [c_SPW-1:0] c_SP_FULL   = c_SPW'(CC_DEPTH);
    localparam logic [c_SPW-1:0] c_SP_ONE    = c_SPW'(1);

    localparam logic [3:0] c_OP_ADD  = 4'h0;
    localparam logic [3:0] c_OP_ADC  = 4'h1;
    localparam logic [3:0] c_OP_SUB  = 4'h2;
    localparam logic [3:0] c_OP_SBC  = 4'h3;
    localparam logic [3:0] c_OP_AND  = 4'h4;
    localparam logic [3:0] c_OP_OR   = 4'h5;
    localparam logic [3:0] c_OP_XOR  = 4'h6;
    localparam logic [3:0] c_OP_NOT  = 4'h7;
    localparam logic [3:0] c_OP_SHL  = 4'h8;
    localparam logic [3:0] c_OP_SHR  = 4'h9;
    localparam logic [3:0] c_OP_ASR  = 4'hA;
    localparam logic [3:0] c_OP_ROL  = 4'hB;
    localparam logic [3:0] c_OP_MUL  = 4'hC;
    localparam logic [3:0] c_OP_MULH = 4'hD;
    localparam logic [3:0] c_OP_CMP  = 4'hE;
    localparam logic [3:0] c_OP_MOV  = 4'hF;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_MUL   = 2'd2;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [3:0]       r_op;
    logic             r_ccl_ld;
    logic [WIDTH-1:0] r_work;      // shift operand, or multiplier / product low half
    logic [WIDTH-1:0] r_mcand;     // multiplicand
    logic [WIDTH-1:0] r_acc;       // product high half
    logic [c_CW-1:0]  r_cnt;       // remaining steps
    logic [WIDTH-1:0] r_res;
    logic             r_done;
    logic             r_cc_z;
    logic             r_cc_c;
    logic             r_cc_s;
    logic             r_cc_p;
    logic             r_cc_err;
    logic [3:0]       r_stack [CC_DEPTH];
    logic [c_SPW-1:0] r_sp;

    logic             w_in_shift;
    logic             w_in_mul;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [c_SHW-1:0] w_shamt;
    logic             w_is_shift;
    logic             w_is_mul;
    logic             w_accept;
    logic             w_go_shift;
    logic             w_go_mul;
    logic             w_single_done;
    logic             w_last;
    logic             w_multi_done;

    assign w_shamt       = B[c_SHW-1:0];
    assign w_is_shift    = (OP >= c_OP_SHL) && (OP <= c_OP_ROL);
    assign w_is_mul      = (OP == c_OP_MUL) || (OP == c_OP_MULH);
    assign w_accept      = START && (r_state == c_ST_IDLE);
    // A zero-distance shift completes like any other single-cycle op.
    assign w_go_shift    = w_accept && w_is_shift && (w_shamt != '0);
    assign w_go_mul      = w_accept && w_is_mul;
    assign w_single_done = w_accept && !w_go_shift && !w_go_mul;
    assign w_last        = (r_cnt == c_CNT_ONE);
    assign w_multi_done  = (r_state != c_ST_IDLE) && w_last;

    // ------------------------------------------------------------------
    // Single-cycle ALU (operates on the live inputs at the accepting edge)
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_c;

    always_comb begin
        w_sum     = '0;
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        case (OP)
            c_OP_ADD: begin
                w_sum     = {1'b0, A} + {1'b0, B};
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
            end
            c_OP_ADC: begin
                w_sum     = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, r_cc_c};
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
            end
            c_OP_SUB, c_OP_CMP: begin
                // The extra top bit of the difference is the borrow.
                w_sum     = {1'b0, A} - {1'b0, B};
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
            end
            c_OP_SBC: begin
                w_sum     = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, r_cc_c};
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
            end
            c_OP_AND: w_alu_res = A & B;
            c_OP_OR:  w_alu_res = A | B;
            c_OP_XOR: w_alu_res = A ^ B;
            c_OP_NOT: w_alu_res = ~A;
            c_OP_MOV: w_alu_res = B;
            c_OP_SHL, c_OP_SHR, c_OP_ASR, c_OP_ROL: w_alu_res = A;
            default:  w_alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // One serial shift step
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_sh_next;
    logic             w_sh_out;

    always_comb begin
        w_sh_next = r_work;
        w_sh_out  = 1'b0;
        case (r_op)
            c_OP_SHL: begin
                w_sh_next = {r_work[WIDTH-2:0], 1'b0};
                w_sh_out  = r_work[WIDTH-1];
            end
            c_OP_SHR: begin
                w_sh_next = {1'b0, r_work[WIDTH-1:1]};
                w_sh_out  = r_work[0];
            end
            c_OP_ASR: begin
                w_sh_next = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
                w_sh_out  = r_work[0];
            end
            c_OP_ROL: begin
                w_sh_next = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
                w_sh_out  = r_work[WIDTH-1];
            end
            default: begin
                w_sh_next = r_work;
                w_sh_out  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // One shift-add multiply step: {acc,work} <= ({acc + (work[0]?M:0)}, work) >> 1
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_mul_add;
    logic [WIDTH-1:0] w_mul_acc_nxt;
    logic [WIDTH-1:0] w_mul_q_nxt;

    assign w_mul_add     = {1'b0, r_acc} + (r_work[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_mul_acc_nxt = w_mul_add[WIDTH:1];
    assign w_mul_q_nxt   = {w_mul_add[0], r_work[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // Completion: select result, carry and flag-load enable
    // ------------------------------------------------------------------
    logic             w_done;
    logic [WIDTH-1:0] w_done_res;
    logic             w_done_c;
    logic             w_done_ld;
    logic             w_done_wr_r;
    logic             w_new_z;
    logic             w_new_s;
    logic             w_new_p;

    assign w_done = w_single_done || w_multi_done;

    always_comb begin
        w_done_res  = w_alu_res;
        w_done_c    = w_alu_c;
        w_done_ld   = CCL_LD;
        w_done_wr_r = (OP != c_OP_CMP);
        if (!w_single_done) begin
            w_done_ld   = r_ccl_ld;
            w_done_wr_r = 1'b1;
            if (w_in_shift) begin
                w_done_res = w_sh_next;
                w_done_c   = w_sh_out;
            end else if (r_op == c_OP_MULH) begin
                w_done_res = w_mul_acc_nxt;
                w_done_c   = |w_mul_q_nxt;
            end else begin
                w_done_res = w_mul_q_nxt;
                w_done_c   = |w_mul_acc_nxt;
            end
        end
    end

    assign w_new_z = (w_done_res == '0);
    assign w_new_s = w_done_res[WIDTH-1];
    assign w_new_p = ^w_done_res;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_go_shift) begin
                    w_state_nxt = c_ST_SHIFT;
                end else if (w_go_mul) begin
                    w_state_nxt = c_ST_MUL;
                end
            end
            c_ST_SHIFT, c_ST_MUL: begin
                if (w_last) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        BUSY       = (r_state != c_ST_IDLE);
        w_in_shift = (r_state == c_ST_SHIFT);
        w_in_mul   = (r_state == c_ST_MUL);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_op     <= '0;
            r_ccl_ld <= 1'b0;
            r_work   <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_res    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_done;
            if (w_done && w_done_wr_r) begin
                r_res <= w_done_res;
            end
            if (w_accept) begin
                r_op     <= OP;
                r_ccl_ld <= CCL_LD;
                r_mcand  <= A;
                r_acc    <= '0;
                r_work   <= w_is_mul ? B : A;
                r_cnt    <= w_is_mul ? c_MUL_STEPS : {1'b0, w_shamt};
            end else if (w_in_shift) begin
                r_work <= w_sh_next;
                r_cnt  <= r_cnt - c_CNT_ONE;
            end else if (w_in_mul) begin
                r_acc  <= w_mul_acc_nxt;
                r_work <= w_mul_q_nxt;
                r_cnt  <= r_cnt - c_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Condition codes and save/restore stack
    // ------------------------------------------------------------------
    logic            w_full;
    logic            w_empty;
    logic            w_push_ok;
    logic            w_pop_ok;
    logic            w_cc_err;
    logic [c_IW-1:0] w_push_idx;
    logic [c_IW-1:0] w_pop_idx;
    logic [3:0]      w_cc_now;

    assign w_full     = (r_sp == c_SP_FULL);
    assign w_empty    = (r_sp == '0);
    assign w_push_ok  = CC_PUSH && !CC_POP && !w_full;
    assign w_pop_ok   = CC_POP && !CC_PUSH && !w_empty;
    assign w_cc_err   = (CC_PUSH && CC_POP) || (CC_PUSH && w_full) || (CC_POP && w_empty);
    assign w_push_idx = c_IW'(r_sp);
    assign w_pop_idx  = c_IW'(r_sp - c_SP_ONE);
    assign w_cc_now   = {r_cc_z, r_cc_c, r_cc_s, r_cc_p};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cc_z   <= 1'b0;
            r_cc_c   <= 1'b0;
            r_cc_s   <= 1'b0;
            r_cc_p   <= 1'b0;
            r_cc_err <= 1'b0;
            r_sp     <= '0;
            for (int i = 0; i < CC_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            r_cc_err <= w_cc_err;
            // A restore wins over a flag update completing on the same edge.
            if (w_pop_ok) begin
                {r_cc_z, r_cc_c, r_cc_s, r_cc_p} <= r_stack[w_pop_idx];
            end else if (w_done && w_done_ld) begin
                {r_cc_z, r_cc_c, r_cc_s, r_cc_p} <= {w_new_z, w_done_c, w_new_s, w_new_p};
            end
            if (w_push_ok) begin
                r_stack[w_push_idx] <= w_cc_now;
                r_sp                <= r_sp + c_SP_ONE;
            end else if (w_pop_ok) begin
                r_sp <= r_sp - c_SP_ONE;
            end
        end
    end

    assign R         = r_res;
    assign DONE      = r_done;
    assign CC_ZERO   = r_cc_z;
    assign CC_CARRY  = r_cc_c;
    assign CC_SIGN   = r_cc_s;
    assign CC_PARITY = r_cc_p;
    assign CC_ERR    = r_cc_err;

endmodule
`default_nettype wire
